// File: rtl/display_arb.sv
// display_arb -- scan sequencer and two-requester arbiter for the 4-digit
// 14-segment display path.
//
// Generates the digit-scan tick, the digit index and the frame boundary, and
// shares the single display between two 16-bit BCD sources. Ownership and the
// displayed value change only on frame boundaries, so one frame never shows a
// mix of two sources.
//
// Parameters:
//   PRESCALE     clk cycles per digit step (>= 2); period of scan_tick
//   HOLD_FRAMES  minimum completed frames a grant is kept while the other
//                side requests (>= 1)
//
// Ports:
//   clk         system clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   req0/req1   requester wants the display (level)
//   bcds0/bcds1 requester value, 4 BCD nibbles, [3:0] = rightmost digit
//   blink       (DISPLAY_ARB_BLINK_EN only) blank every other 16 frames
//   gnt0/gnt1   requester owns the display (never both high)
//   bcds_out    frame-latched value fed to the segment decoder
//   dig_sel     active digit index, 0 = rightmost
//   scan_tick   one-cycle pulse per digit step
//   frame_done  one-cycle pulse when dig_sel wraps 3 -> 0
//
// Optional feature macro: DISPLAY_ARB_BLINK_EN
//   Adds the blink input and a 5-bit frame counter. While blink=1 and counter
//   bit 4 is set, bcds_out reads all-dark; the latched value is kept intact.

module display_arb #(
    parameter int unsigned PRESCALE    = 16,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] bcds0,
    input  logic        req1,
    input  logic [15:0] bcds1,
`ifdef DISPLAY_ARB_BLINK_EN
    input  logic        blink,
`endif
    output logic        gnt0,
    output logic        gnt1,
    output logic [15:0] bcds_out,
    output logic [1:0]  dig_sel,
    output logic        scan_tick,
    output logic        frame_done
);

    localparam int unsigned      CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned      HW       = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(PRESCALE - 1);
    localparam logic [HW-1:0]    HOLD_SAT = HW'(HOLD_FRAMES);
    localparam logic [15:0]      DARK     = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    // ------------------------------------------------------------------
    // Prescaler and digit scan
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_sel_q;
    logic          scan_tick_q;
    logic          frame_done_q;
    logic          boundary;
    logic          frame_bnd;

    assign boundary  = (cnt_q == CNT_MAX);
    assign frame_bnd = boundary && (dig_sel_q == 2'd3);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (boundary) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dig_sel_q    <= '0;
            scan_tick_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            scan_tick_q  <= boundary;
            frame_done_q <= frame_bnd;
            if (boundary) begin
                dig_sel_q <= dig_sel_q + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          gnt0_q, gnt1_q;
    logic [15:0]   bcds_q;
    logic [HW-1:0] hold_q;
    logic          last_q;       // side granted most recently; the other wins a tie from IDLE
    logic          hold_expired;

    assign hold_expired = (32'(hold_q) + 32'd1 >= HOLD_FRAMES);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end else if (req1 && hold_expired) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end else if (req0 && hold_expired) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All arbiter outputs are registered and only move on the frame
    // boundary edge, the same edge that raises frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            bcds_q  <= DARK;
            hold_q  <= '0;
            last_q  <= 1'b1;
        end else if (frame_bnd) begin
            state_q <= state_d;
            unique case (state_d)
                OWN0: begin
                    gnt0_q <= 1'b1;
                    gnt1_q <= 1'b0;
                    bcds_q <= bcds0;
                    last_q <= 1'b0;
                    if (state_q != OWN0) begin
                        hold_q <= '0;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                OWN1: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b1;
                    bcds_q <= bcds1;
                    last_q <= 1'b1;
                    if (state_q != OWN1) begin
                        hold_q <= '0;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    bcds_q <= DARK;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign dig_sel    = dig_sel_q;
    assign scan_tick  = scan_tick_q;
    assign frame_done = frame_done_q;

`ifdef DISPLAY_ARB_BLINK_EN
    logic [4:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_bnd) begin
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end

    // Blanking is applied after the latch so the owner's value survives the
    // dark half of the blink period untouched.
    assign bcds_out = (blink && frame_cnt_q[4]) ? DARK : bcds_q;
`else
    assign bcds_out = bcds_q;
`endif

endmodule
